// File: rtl/execute_pipe.sv
// Execute stage: single-cycle integer ALU plus an iterative multiplier.
// It has a registered output, and opcode and rd travel with the result.
//
// Handshake: a transfer happens on a side only when valid && ready are both
// high at a rising clock edge. A producer holds its payload stable while valid
// is high and ready is low. A consumer may raise or lower ready at any time.
module execute_pipe #(
    parameter int XLEN     = 32,
    parameter int IMM_W    = 20,
    parameter int OP_W     = 5,
    parameter int MUL_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  opcode_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic [4:0]       rd_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OP_W-1:0]  opcode_o,
    output logic [4:0]       rd_o,
    output logic [XLEN-1:0]  alu_result_o,
    output logic             illegal_o,
    output logic [1:0]       dbg_state
);

    localparam int MUL_CYCLES = XLEN / MUL_STEP;
    localparam int CNT_W      = $clog2(MUL_CYCLES + 1);
    localparam int SH_W       = $clog2(XLEN);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MUL_BUSY = 2'd1;
    localparam logic [1:0] S_MUL_DONE = 2'd2;

    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(10);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(11);

    logic [1:0]       state;
    logic [CNT_W-1:0] mul_cnt;
    logic [XLEN-1:0]  mul_acc;
    logic [XLEN-1:0]  mul_mcand;
    logic [XLEN-1:0]  mul_mplier;
    logic [4:0]       mul_rd;

    logic [XLEN-1:0]  imm_ext;
    logic [SH_W-1:0]  shamt;
    logic [XLEN-1:0]  alu_res;
    logic             alu_ill;
    logic [XLEN-1:0]  mul_partial;
    logic             out_free;
    logic             accept;
    logic             is_mul;
    logic             mul_write;

    assign imm_ext     = {{(XLEN-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign shamt       = rs2_i[SH_W-1:0];
    assign mul_partial = mul_mcand * XLEN'(mul_mplier[MUL_STEP-1:0]);

    // The output register can take a new result when it is empty or is being drained.
    assign out_free   = !out_valid_o || out_ready_i;
    assign in_ready_o = (state == S_IDLE) && !flush_i && out_free;
    assign accept     = in_valid_i && in_ready_o;
    assign is_mul     = (opcode_i == OP_MUL);
    assign mul_write  = (state == S_MUL_DONE) && out_free && !flush_i;
    assign dbg_state  = state;

    // Single-cycle ALU. MUL yields 0 here because its result comes from the FSM.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (opcode_i)
            OP_ADDI: alu_res = rs1_i + imm_ext;
            OP_ADD:  alu_res = rs1_i + rs2_i;
            OP_SUB:  alu_res = rs1_i - rs2_i;
            OP_AND:  alu_res = rs1_i & rs2_i;
            OP_OR:   alu_res = rs1_i | rs2_i;
            OP_XOR:  alu_res = rs1_i ^ rs2_i;
            OP_SLL:  alu_res = rs1_i << shamt;
            OP_SRL:  alu_res = rs1_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(rs1_i) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_i) < $signed(rs2_i))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (rs1_i < rs2_i)};
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // Multiplier FSM. Each busy cycle retires MUL_STEP multiplier bits (shift-add).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_rd     <= '0;
        end else if (flush_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_mul) begin
                        state      <= S_MUL_BUSY;
                        mul_cnt    <= CNT_W'(MUL_CYCLES);
                        mul_acc    <= '0;
                        mul_mcand  <= rs1_i;
                        mul_mplier <= rs2_i;
                        mul_rd     <= rd_i;
                    end
                end
                S_MUL_BUSY: begin
                    mul_acc    <= mul_acc + mul_partial;
                    mul_mcand  <= mul_mcand << MUL_STEP;
                    mul_mplier <= mul_mplier >> MUL_STEP;
                    mul_cnt    <= mul_cnt - CNT_W'(1);
                    if (mul_cnt == CNT_W'(1)) begin
                        state <= S_MUL_DONE;
                    end
                end
                S_MUL_DONE: begin
                    if (out_free) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register. Flush drops the held result, MUL completion takes priority
    // over the ALU (they never coincide), and a consume empties the register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o  <= 1'b0;
            opcode_o     <= '0;
            rd_o         <= '0;
            alu_result_o <= '0;
            illegal_o    <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (mul_write) begin
            out_valid_o  <= 1'b1;
            opcode_o     <= OP_MUL;
            rd_o         <= mul_rd;
            alu_result_o <= mul_acc;
            illegal_o    <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid_o  <= 1'b1;
            opcode_o     <= opcode_i;
            rd_o         <= rd_i;
            alu_result_o <= alu_res;
            illegal_o    <= alu_ill;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// Bench for execute_pipe: directed multi-cycle sequences plus a vector table,
// with a scoreboard queue checking every delivered result in order.
module tb_execute_pipe;

    localparam int W = 5 + 5 + 1 + 32;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [19:0] imm;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [19:0] imm;
    logic [4:0]  rd;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [31:0] alu_result;
    logic        illegal;
    logic [1:0]  dbg_state;

    logic        man_ready;
    logic        rnd_ready;
    logic        rand_ready;

    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    vec_t vecs[21];

    assign out_ready = rand_ready ? rnd_ready : man_ready;

    execute_pipe dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .opcode_i(opcode), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .rd_i(rd),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .opcode_o(opcode_o), .rd_o(rd_o), .alu_result_o(alu_result),
        .illegal_o(illegal), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Random downstream backpressure, updated just after each rising edge
    initial begin
        rnd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every consumed result must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got op=%0d rd=%0d res=0x%0h required no result",
                         opcode_o, rd_o, alu_result);
            end else begin
                check("sb_result", 64'({opcode_o, rd_o, illegal, alu_result}), 64'(exp_q.pop_front()));
            end
        end else if (!rst && out_valid && flush && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    end

    // Driver: offer one operation, wait (bounded) for acceptance, push its expectation
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [19:0] im, input logic [4:0] d, input logic [31:0] res,
                        input logic ill, input bit push, output int waited);
        bit got;
        in_valid = 1'b1;
        opcode   = op;
        rs1      = a;
        rs2      = b;
        imm      = im;
        rd       = d;
        waited   = 0;
        got      = 1'b0;
        while (!got && waited < 100) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 100 cycles required acceptance (op=%0d)", op);
            in_valid = 1'b0;
        end else begin
            if (push) exp_q.push_back({op, d, ill, res});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int w;
        int bad;

        vecs[0]  = '{5'd1,  32'h7FFF_FFFF, 32'h0000_0001, 20'h0,     32'h8000_0000, 1'b0};
        vecs[1]  = '{5'd1,  32'hFFFF_FFFF, 32'h0000_0002, 20'h0,     32'h0000_0001, 1'b0};
        vecs[2]  = '{5'd2,  32'h0000_0000, 32'h0000_0001, 20'h0,     32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{5'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 20'h0,     32'hF000_F000, 1'b0};
        vecs[4]  = '{5'd4,  32'hF0F0_F0F0, 32'h0F00_0F00, 20'h0,     32'hFFF0_FFF0, 1'b0};
        vecs[5]  = '{5'd5,  32'hAAAA_5555, 32'hFFFF_0000, 20'h0,     32'h5555_5555, 1'b0};
        vecs[6]  = '{5'd6,  32'h0000_0001, 32'd31,        20'h0,     32'h8000_0000, 1'b0};
        vecs[7]  = '{5'd6,  32'h0000_0003, 32'h0000_0021, 20'h0,     32'h0000_0006, 1'b0};
        vecs[8]  = '{5'd7,  32'h8000_0000, 32'd31,        20'h0,     32'h0000_0001, 1'b0};
        vecs[9]  = '{5'd8,  32'h8000_0000, 32'd31,        20'h0,     32'hFFFF_FFFF, 1'b0};
        vecs[10] = '{5'd9,  32'hFFFF_FFFF, 32'h0000_0001, 20'h0,     32'h0000_0001, 1'b0};
        vecs[11] = '{5'd10, 32'hFFFF_FFFF, 32'h0000_0001, 20'h0,     32'h0000_0000, 1'b0};
        vecs[12] = '{5'd0,  32'h0000_0100, 32'h0000_0000, 20'h7FFFF, 32'h0008_00FF, 1'b0};
        vecs[13] = '{5'd0,  32'h0000_0005, 32'h0000_0000, 20'h80000, 32'hFFF8_0005, 1'b0};
        vecs[14] = '{5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 20'h0,     32'h0000_0001, 1'b0};
        vecs[15] = '{5'd11, 32'h1234_5678, 32'h0000_0010, 20'h0,     32'h2345_6780, 1'b0};
        vecs[16] = '{5'd11, 32'h0001_0000, 32'h0001_0000, 20'h0,     32'h0000_0000, 1'b0};
        vecs[17] = '{5'd12, 32'h0000_0005, 32'h0000_0005, 20'h0,     32'h0000_0000, 1'b1};
        vecs[18] = '{5'd31, 32'h0000_0005, 32'h0000_0005, 20'h0,     32'h0000_0000, 1'b1};
        vecs[19] = '{5'd8,  32'h7FFF_FFF0, 32'h0000_0004, 20'h0,     32'h07FF_FFFF, 1'b0};
        vecs[20] = '{5'd9,  32'h0000_0001, 32'hFFFF_FFFF, 20'h0,     32'h0000_0000, 1'b0};

        // Reset
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; opcode = '0; rs1 = '0; rs2 = '0;
        imm = '0; rd = '0; man_ready = 1'b1; rand_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_opcode",    64'(opcode_o),  64'd0);
        check("rst_rd",        64'(rd_o),      64'd0);
        check("rst_result",    64'(alu_result), 64'd0);
        check("rst_illegal",   64'(illegal),   64'd0);
        check("rst_state",     64'(dbg_state), 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // 1: ADDI 0x10 + (-1), latency 1
        send(5'd0, 32'h10, 32'h0, 20'hFFFFF, 5'd3, 32'h0000_000F, 1'b0, 1'b1, w);
        check("t1_valid",  64'(out_valid),  64'd1);
        check("t1_result", 64'(alu_result), 64'h0000_000F);
        check("t1_opcode", 64'(opcode_o),   64'd0);
        check("t1_rd",     64'(rd_o),       64'd3);

        // 2: back-to-back stream, no bubbles
        send(5'd2, 32'd5, 32'd7, 20'h0, 5'd4, 32'hFFFF_FFFE, 1'b0, 1'b1, w);
        check("t2_sub_wait", 64'(w), 64'd0);
        check("t2_sub", 64'({out_valid, alu_result}), {31'd0, 1'b1, 32'hFFFF_FFFE});
        send(5'd8, 32'h8000_0000, 32'd4, 20'h0, 5'd5, 32'hF800_0000, 1'b0, 1'b1, w);
        check("t2_sra_wait", 64'(w), 64'd0);
        check("t2_sra", 64'({out_valid, alu_result}), {31'd0, 1'b1, 32'hF800_0000});
        send(5'd10, 32'd1, 32'hFFFF_FFFF, 20'h0, 5'd6, 32'h1, 1'b0, 1'b1, w);
        check("t2_sltu_wait", 64'(w), 64'd0);
        check("t2_sltu", 64'({out_valid, alu_result}), {31'd0, 1'b1, 32'h1});

        // 3: MUL latency, 8 busy cycles then result on the 9th edge
        send(5'd11, 32'h0001_0003, 32'h0000_0100, 20'h0, 5'd7, 32'h0100_0300, 1'b0, 1'b1, w);
        check("t3_state_busy", 64'(dbg_state), 64'd1);
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
            if (i == 8) check("t3_state_done", 64'(dbg_state), 64'd2);
            @(posedge clk); #1;
        end
        check("t3_busy_window", 64'(bad), 64'd0);
        check("t3_valid",  64'(out_valid),  64'd1);
        check("t3_result", 64'(alu_result), 64'h0100_0300);
        check("t3_rd",     64'(rd_o),       64'd7);
        @(posedge clk); #1;

        // 4: backpressure holds outputs; consume and accept in the same cycle
        man_ready = 1'b0;
        send(5'd1, 32'd1, 32'd1, 20'h0, 5'd1, 32'd2, 1'b0, 1'b1, w);
        in_valid = 1'b1; opcode = 5'd1; rs1 = 32'd2; rs2 = 32'd2; rd = 5'd2;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_result !== 32'd2 ||
                rd_o !== 5'd1 || opcode_o !== 5'd1 || illegal !== 1'b0) bad++;
        end
        check("t4_stall_stable", 64'(bad), 64'd0);
        @(posedge clk); #1;
        man_ready = 1'b1;
        send(5'd1, 32'd2, 32'd2, 20'h0, 5'd2, 32'd4, 1'b0, 1'b1, w);
        check("t4_same_cycle_accept", 64'(w), 64'd0);
        check("t4_second", 64'({out_valid, rd_o, alu_result}), {26'd0, 1'b1, 5'd2, 32'd4});
        @(posedge clk); #1;

        // 5: flush at busy cycle 4 of a MUL
        send(5'd11, 32'd3, 32'd5, 20'h0, 5'd8, 32'd15, 1'b0, 1'b0, w);
        repeat (3) @(posedge clk);
        #1;
        check("t5_busy_before_flush", 64'(dbg_state), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("t5_state_idle", 64'(dbg_state), 64'd0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("t5_no_result", 64'(bad), 64'd0);
        send(5'd1, 32'd2, 32'd3, 20'h0, 5'd9, 32'd5, 1'b0, 1'b1, w);
        check("t5_add_after", 64'({out_valid, alu_result}), {31'd0, 1'b1, 32'd5});
        @(posedge clk); #1;
        in_valid = 1'b1; opcode = 5'd1; rs1 = 32'd9; rs2 = 32'd9; rd = 5'd10;
        flush = 1'b1;
        @(negedge clk);
        check("t5_flush_blocks_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("t5_flush_not_accepted", 64'(out_valid), 64'd0);

        // 6: illegal opcode, then reset in the middle of a MUL
        send(5'd31, 32'd1, 32'd1, 20'h0, 5'd11, 32'd0, 1'b1, 1'b1, w);
        check("t6_illegal", 64'({out_valid, illegal, alu_result}), {30'd0, 1'b1, 1'b1, 32'd0});
        send(5'd11, 32'd7, 32'd6, 20'h0, 5'd12, 32'd42, 1'b0, 1'b0, w);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_clear",
              64'({out_valid, opcode_o, rd_o, illegal, alu_result}), 64'd0);
        check("t6_state_idle", 64'(dbg_state), 64'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(negedge clk);
        check("t6_ready_after_rst", 64'(in_ready), 64'd1);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        check("t6_no_mul_result", 64'(bad), 64'd0);

        // Vector table under random downstream backpressure
        @(posedge clk); #3;
        rand_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, 5'(i + 13),
                 vecs[i].res, vecs[i].ill, 1'b1, w);
        end
        @(posedge clk); #3;
        rand_ready = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #3;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
